pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
Per-core fetch sequencer that drives the enable / write-enable / load-address inputs of the core's PC counter.
Arbitrates redirect sources (halt, branch, jump, optional interrupt) against pipeline stall. Generates a fixed-length flush window after every redirect, and tracks halt/resume.
Sits between decode/execute control and the PC counter, one instance per core.

Parameters:
INST_ADDR_WIDTH, 6, width of every instruction address (targets, vectors, pc_cur, pc_load_addr, epc).
FLUSH_CYCLES, 2, cycles of flush asserted after a redirect; legal range 1..15.
IRQ_VECTOR, 6'h3C, interrupt handler address (used only with the optional feature).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
stall  in  1  pipeline stall; freezes PC while in RUN
branch_req  in  1  taken-branch redirect request, single-cycle pulse
branch_target  in  INST_ADDR_WIDTH  branch destination
jump_req  in  1  jump redirect request, single-cycle pulse
jump_target  in  INST_ADDR_WIDTH  jump destination
halt_req  in  1  stop fetch (level or pulse)
resume  in  1  leave HALT
pc_cur  in  INST_ADDR_WIDTH  current PC value read back from the PC counter
irq  in  1  interrupt request, level (optional feature)
pc_en  out  1  PC counter enable
pc_wen  out  1  PC counter load strobe; meaningful only with pc_en=1
pc_load_addr  out  INST_ADDR_WIDTH  address to load when pc_wen=1
flush  out  1  kill in-flight fetch/decode
halted  out  1  high while in HALT
epc  out  INST_ADDR_WIDTH  saved return PC (optional feature)
state  out  2  encoded state: RUN=0, LOAD=1, FLUSH=2, HALT=3

Behaviour:
- Reset values: state=RUN, pc_en=0, pc_wen=0, pc_load_addr=0, flush=0, halted=0, epc=0, flush counter=0.
  - Reset is synchronous and overrides everything; reset mid-FLUSH or mid-HALT returns to RUN the next cycle.
- All outputs are registered. A decision made in cycle N appears on the outputs in cycle N+1.
- RUN
  - Outputs: pc_en = !stall, pc_wen=0, flush=0.
  - Request priority, evaluated every cycle: halt_req > irq > branch_req > jump_req.
  - halt_req -> HALT.
  - Any redirect -> LOAD, latching the winner's target into pc_load_addr. Lower-priority requests in the same cycle are dropped, not queued.
  - A redirect is accepted even while stall=1; redirect beats stall.
- LOAD (exactly 1 cycle)
  - Outputs: pc_en=1, pc_wen=1, flush=1.
  - Flush counter is loaded with FLUSH_CYCLES-1.
  - Next state: FLUSH if FLUSH_CYCLES>1, else RUN.
- FLUSH
  - Outputs: pc_en=0, pc_wen=0, flush=1.
  - Counter decrements each cycle; transition to RUN when the counter reaches 0.
  - Total flush high time = FLUSH_CYCLES cycles, including LOAD.
  - Redirect requests arriving during LOAD or FLUSH are ignored.
  - halt_req during FLUSH is taken at the first RUN cycle only if it is still asserted then.
- HALT
  - Outputs: pc_en=0, pc_wen=0, flush=0, halted=1.
  - resume=1 and halt_req=0 -> RUN. If both are asserted, stay in HALT.
  - branch_req and jump_req are ignored.
- pc_load_addr holds its last value when not loading.
- stall is ignored outside RUN.

Optional Feature:
- Macro: PC_CTRL_IRQ_EN.
- Defined:
  - irq is evaluated in RUN and in HALT; in HALT it acts as a wake-up and takes priority over resume.
  - On acceptance: epc <= pc_cur and pc_load_addr <= IRQ_VECTOR, then LOAD -> FLUSH as for any redirect.
  - irq is masked from acceptance until the first RUN cycle after the flush, which prevents re-entry on a level irq.
- Undefined: the irq input is unused, epc is tied to 0, and no interrupt logic is synthesised.

Test Plan:
- Reset with stall=0 -> pc_en=0 in the reset cycle, pc_en=1 from the first cycle after reset release; all other outputs 0; state=0.
- branch_req=1, branch_target=6'h12 in RUN -> next cycle pc_en=1, pc_wen=1, pc_load_addr=6'h12, flush=1; flush high 2 cycles total; pc_en back to 1 on cycle 3.
- branch_req and jump_req together (0x12 / 0x20) with stall=1 -> pc_load_addr=0x12; jump dropped; stall overridden for the LOAD cycle.
- halt_req pulse -> halted=1, pc_en=0; resume with halt_req=1 -> stays HALT; resume alone -> RUN, pc_en=!stall.
- Reset asserted during FLUSH (FLUSH_CYCLES=4, cycle 2) -> next cycle state=RUN, flush=0, pc_en=0.
- With PC_CTRL_IRQ_EN defined: irq held high with pc_cur=0x07 -> epc=0x07, pc_load_addr=0x3C, exactly one LOAD; from HALT, irq=1 -> LOAD to 0x3C.

Source files
------------

// File: rtl/pc_fetch_ctrl_if.sv
// pc_fetch_ctrl_if: control/address bundle between pipeline control, fetch sequencer and PC counter
interface pc_fetch_ctrl_if #(parameter int INST_ADDR_WIDTH = 6);
  logic stall, branch_req, jump_req, halt_req, resume, irq;
  logic [INST_ADDR_WIDTH-1:0] branch_target, jump_target, pc_cur;
  logic pc_en, pc_wen, flush, halted;
  logic [INST_ADDR_WIDTH-1:0] pc_load_addr, epc;
  logic [1:0] state;
  modport master(
    output stall, branch_req, branch_target, jump_req, jump_target, halt_req, resume, pc_cur, irq,
    input pc_en, pc_wen, pc_load_addr, flush, halted, epc, state
  );
  modport slave(
    input stall, branch_req, branch_target, jump_req, jump_target, halt_req, resume, pc_cur, irq,
    output pc_en, pc_wen, pc_load_addr, flush, halted, epc, state
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: PC redirect/stall/flush/halt sequencer; interrupt support enabled by PC_CTRL_IRQ_EN
module pc_fetch_ctrl #(
  parameter int INST_ADDR_WIDTH = 6,
  parameter int FLUSH_CYCLES = 2,
  parameter logic [INST_ADDR_WIDTH-1:0] IRQ_VECTOR = 6'h3C
) (
  input logic clk,
  input logic reset,
  pc_fetch_ctrl_if.slave io
);
  typedef enum logic [1:0] {RUN = 2'd0, LOAD = 2'd1, FLUSH = 2'd2, HALT = 2'd3} state_t;
  state_t st;
  logic [3:0] cnt;
  logic irq_go, load_go, to_halt;
  logic [INST_ADDR_WIDTH-1:0] tgt;
  assign io.state = st;
`ifdef PC_CTRL_IRQ_EN
  logic irq_mask;
  // mask stays set through LOAD/FLUSH and the first RUN cycle so a held level irq is taken once
  assign irq_go = io.irq && !irq_mask && (st == HALT || (st == RUN && !io.halt_req));
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_mask <= 1'b0;
      io.epc <= '0;
    end else if (irq_go) begin
      irq_mask <= 1'b1;
      io.epc <= io.pc_cur;
    end else if (st == RUN) irq_mask <= 1'b0;
  end
`else
  logic unused_irq;
  assign unused_irq = io.irq ^ (^io.pc_cur);
  assign irq_go = 1'b0;
  assign io.epc = '0;
`endif
  always_comb begin
    load_go = irq_go || (st == RUN && !io.halt_req && (io.branch_req || io.jump_req));
    to_halt = st == RUN ? io.halt_req : !(io.resume && !io.halt_req);
    tgt = irq_go ? IRQ_VECTOR : io.branch_req ? io.branch_target : io.jump_target;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= RUN;
      cnt <= '0;
      io.pc_en <= 1'b0;
      io.pc_wen <= 1'b0;
      io.pc_load_addr <= '0;
      io.flush <= 1'b0;
      io.halted <= 1'b0;
    end else begin
      io.pc_en <= !io.stall;
      io.pc_wen <= 1'b0;
      io.flush <= 1'b0;
      io.halted <= 1'b0;
      case (st)
        LOAD: begin
          cnt <= 4'(FLUSH_CYCLES - 1);
          if (FLUSH_CYCLES > 1) begin
            st <= FLUSH;
            io.pc_en <= 1'b0;
            io.flush <= 1'b1;
          end else st <= RUN;
        end
        FLUSH: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) st <= RUN;
          else begin
            io.pc_en <= 1'b0;
            io.flush <= 1'b1;
          end
        end
        default: begin
          if (load_go) begin
            st <= LOAD;
            io.pc_en <= 1'b1;
            io.pc_wen <= 1'b1;
            io.flush <= 1'b1;
            io.pc_load_addr <= tgt;
          end else if (to_halt) begin
            st <= HALT;
            io.pc_en <= 1'b0;
            io.halted <= 1'b1;
          end else st <= RUN;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed checks of pc_fetch_ctrl with FLUSH_CYCLES=2 (u0) and FLUSH_CYCLES=4 (u1)
module tb_pc_fetch_ctrl;
  logic clk = 1'b0, reset = 1'b1;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  pc_fetch_ctrl_if #(.INST_ADDR_WIDTH(6)) if0 ();
  pc_fetch_ctrl_if #(.INST_ADDR_WIDTH(6)) if1 ();
  pc_fetch_ctrl #(.INST_ADDR_WIDTH(6), .FLUSH_CYCLES(2), .IRQ_VECTOR(6'h3C)) u0 (.clk(clk), .reset(reset), .io(if0));
  pc_fetch_ctrl #(.INST_ADDR_WIDTH(6), .FLUSH_CYCLES(4), .IRQ_VECTOR(6'h3C)) u1 (.clk(clk), .reset(reset), .io(if1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    {if0.stall, if0.branch_req, if0.jump_req, if0.halt_req, if0.resume, if0.irq} = '0;
    {if1.stall, if1.branch_req, if1.jump_req, if1.halt_req, if1.resume, if1.irq} = '0;
    {if0.branch_target, if0.jump_target, if0.pc_cur} = '0;
    {if1.branch_target, if1.jump_target, if1.pc_cur} = '0;
    step;
    check("rst_pc_en", if0.pc_en, 0);
    check("rst_state", if0.state, 0);
    check("rst_outs", {if0.pc_wen, if0.flush, if0.halted, if0.pc_load_addr, if0.epc}, 0);
    check("rst_u1", {if1.pc_en, if1.state, if1.flush}, 0);
    reset = 1'b0;
    step;
    check("run_pc_en", if0.pc_en, 1);
    check("run_outs", {if0.pc_wen, if0.flush, if0.halted, if0.state}, 0);
    // single branch, with a jump arriving during LOAD that must be ignored
    if0.branch_req = 1'b1; if0.branch_target = 6'h12;
    step;
    check("br_load", {if0.pc_en, if0.pc_wen, if0.flush, if0.state}, {3'b111, 2'd1});
    check("br_addr", if0.pc_load_addr, 6'h12);
    if0.branch_req = 1'b0; if0.jump_req = 1'b1; if0.jump_target = 6'h33;
    step;
    if0.jump_req = 1'b0;
    check("br_flush", {if0.pc_en, if0.pc_wen, if0.flush, if0.state}, {3'b001, 2'd2});
    check("br_addr_hold", if0.pc_load_addr, 6'h12);
    step;
    check("br_done", {if0.pc_en, if0.pc_wen, if0.flush, if0.state}, {3'b100, 2'd0});
    // simultaneous branch and jump under stall
    if0.stall = 1'b1; if0.branch_req = 1'b1; if0.jump_req = 1'b1; if0.jump_target = 6'h20;
    step;
    if0.branch_req = 1'b0; if0.jump_req = 1'b0;
    check("bj_load", {if0.pc_en, if0.pc_wen, if0.flush}, 3'b111);
    check("bj_addr", if0.pc_load_addr, 6'h12);
    step;
    check("bj_flush", {if0.pc_en, if0.flush, if0.state}, {2'b01, 2'd2});
    step;
    check("bj_run_stalled", {if0.pc_en, if0.flush, if0.state}, 4'd0);
    step;
    check("bj_no_queue", {if0.state, if0.pc_load_addr}, {2'd0, 6'h12});
    if0.stall = 1'b0;
    step;
    check("stall_release", if0.pc_en, 1);
    // halt / resume
    if0.halt_req = 1'b1;
    step;
    if0.halt_req = 1'b0; if0.branch_req = 1'b1; if0.branch_target = 6'h05;
    check("halt_enter", {if0.halted, if0.pc_en, if0.state}, {2'b10, 2'd3});
    step;
    if0.branch_req = 1'b0;
    check("halt_ign_br", {if0.halted, if0.state, if0.pc_load_addr}, {1'b1, 2'd3, 6'h12});
    if0.resume = 1'b1; if0.halt_req = 1'b1;
    step;
    check("halt_both", {if0.halted, if0.state}, {1'b1, 2'd3});
    if0.halt_req = 1'b0;
    step;
    if0.resume = 1'b0;
    check("resume", {if0.halted, if0.pc_en, if0.state}, {2'b01, 2'd0});
    // halt_req raised during flush is taken only once RUN is reached
    if0.jump_req = 1'b1; if0.jump_target = 6'h2B;
    step;
    if0.jump_req = 1'b0; if0.halt_req = 1'b1;
    check("jmp_addr", {if0.state, if0.pc_load_addr}, {2'd1, 6'h2B});
    step;
    check("fl_halt_ign", if0.state, 2);
    step;
    check("fl_halt_run", if0.state, 0);
    step;
    if0.halt_req = 1'b0; if0.resume = 1'b1;
    check("fl_halt_late", {if0.halted, if0.state}, {1'b1, 2'd3});
    step;
    if0.resume = 1'b0;
    check("fl_halt_out", if0.state, 0);
`ifdef PC_CTRL_IRQ_EN
    if0.pc_cur = 6'h07; if0.irq = 1'b1;
    step;
    check("irq_load", {if0.state, if0.pc_load_addr, if0.epc}, {2'd1, 6'h3C, 6'h07});
    if0.pc_cur = 6'h3C;
    step;
    check("irq_flush", if0.state, 2);
    step;
    check("irq_run", if0.state, 0);
    step;
    if0.irq = 1'b0;
    check("irq_once", {if0.state, if0.epc}, {2'd0, 6'h07});
    if0.halt_req = 1'b1;
    step;
    if0.halt_req = 1'b0; if0.irq = 1'b1; if0.resume = 1'b1; if0.pc_cur = 6'h11;
    check("irq_halt", if0.state, 3);
    step;
    if0.irq = 1'b0; if0.resume = 1'b0;
    check("irq_wake", {if0.state, if0.pc_load_addr, if0.epc}, {2'd1, 6'h3C, 6'h11});
    step;
    step;
    check("irq_wake_run", if0.state, 0);
`else
    if0.irq = 1'b1; if0.pc_cur = 6'h07;
    step;
    step;
    if0.irq = 1'b0;
    check("irq_off", {if0.state, if0.epc, if0.pc_load_addr}, {2'd0, 6'h00, 6'h2B});
`endif
    // u1: four-cycle flush window, then reset mid-flush
    if1.branch_req = 1'b1; if1.branch_target = 6'h2A;
    for (int i = 0; i < 4; i++) begin
      step;
      if1.branch_req = 1'b0;
      check($sformatf("u1_flush%0d", i), {if1.flush, if1.pc_en}, {1'b1, i == 0});
    end
    step;
    check("u1_flush_end", {if1.flush, if1.pc_en, if1.state}, {2'b01, 2'd0});
    if1.branch_req = 1'b1;
    step;
    if1.branch_req = 1'b0;
    step;
    step;
    check("u1_mid_flush", {if1.flush, if1.state}, {1'b1, 2'd2});
    reset = 1'b1;
    step;
    reset = 1'b0;
    check("u1_rst_flush", {if1.state, if1.flush, if1.pc_en, if1.pc_load_addr}, 10'd0);
    step;
    check("u1_after_rst", {if1.state, if1.pc_en}, {2'd0, 1'b1});
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
